rx_byte_rcvr: RTL

RX_BYTE_RCVR -- requirements
Module: rx_byte_rcvr

---
 rtl/rx_byte_rcvr.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rx_byte_rcvr.sv
// Serial word receiver: synchronizes an external serial clock/data pair into clk,
// assembles NUM_BITS-bit words and hands them to a consumer with ready/overrun flags.
module rx_byte_rcvr #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                serial_clk,
    input  logic                serial_in,
    input  logic                rx_enable,
    input  logic                byte_read,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                data_ready,
    output logic                overrun_error
);

    localparam int CW = $clog2(NUM_BITS + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RECEIVE = 2'd1;
    localparam logic [1:0] LOAD    = 2'd2;

    logic                sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic                sdin_s1_q, sdin_s2_q;
    logic                rise_found;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_BITS-1:0] shreg_q, shreg_d, shifted;
    logic [NUM_BITS-1:0] rx_data_q, rx_data_d;
    logic                ready_q, ready_d;
    logic                ovr_q, ovr_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            sdin_s1_q   <= 1'b0;
            sdin_s2_q   <= 1'b0;
        end else begin
            sclk_s1_q   <= serial_clk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            sdin_s1_q   <= serial_in;
            sdin_s2_q   <= sdin_s1_q;
        end
    end

    assign rise_found = sclk_s2_q & ~sclk_prev_q;

    assign shifted = SHIFT_MSB ? {shreg_q[NUM_BITS-2:0], sdin_s2_q}
                               : {sdin_s2_q, shreg_q[NUM_BITS-1:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        rx_data_d = rx_data_q;
        ready_d   = ready_q;
        ovr_d     = ovr_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_enable) state_d = RECEIVE;
            end
            RECEIVE: begin
                if (!rx_enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (rise_found) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(NUM_BITS - 1)) state_d = LOAD;
                end
            end
            LOAD: begin
                rx_data_d = shreg_q;
                ready_d   = 1'b1;
                cnt_d     = '0;
                // A simultaneous byte_read acknowledges the old word, so no overrun.
                if (ready_q && !byte_read) ovr_d = 1'b1;
                state_d = rx_enable ? RECEIVE : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (state_q != LOAD && byte_read) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            rx_data_q <= '0;
            ready_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            rx_data_q <= rx_data_d;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = ready_q;
    assign overrun_error = ovr_q;

endmodule
